// File: rtl/mdu_unit_pkg.sv
// rtl/mdu_unit_pkg.sv - shared op encodings, default latencies and helpers for the multiply/divide unit
package mdu_unit_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;

    localparam int MDU_MUL_LAT = 5;
    localparam int MDU_DIV_LAT = 10;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    // True for the four ops that occupy the unit for several cycles.
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit_calc.sv
// rtl/mdu_unit_calc.sv - combinational HI/LO result generator for MULT/MULTU/DIV/DIVU
// Ports: op (MDU_* select), a/b operands, res_hi/res_lo result halves.
module mdu_unit_calc
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [2*WIDTH-1:0]      prod;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;

    assign sa = $signed(a);
    assign sb = $signed(b);

    always_comb begin
        prod   = '0;
        res_hi = '0;
        res_lo = '0;
        case (op)
            // Sign-extending to 2*WIDTH makes the modular product equal the signed product.
            MDU_MULT: begin
                prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
                {res_hi, res_lo} = prod;
            end
            MDU_MULTU: begin
                prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
                {res_hi, res_lo} = prod;
            end
            MDU_DIV: begin
                if (b == '0) begin
                    res_lo = '1;
                    res_hi = a;
                end else if ((a == MIN_INT) && (b == '1)) begin
                    res_lo = MIN_INT;
                    res_hi = '0;
                end else begin
                    // Signed / and % truncate toward zero; remainder follows the dividend sign.
                    res_lo = $unsigned(sa / sb);
                    res_hi = $unsigned(sa % sb);
                end
            end
            MDU_DIVU: begin
                if (b == '0) begin
                    res_lo = '1;
                    res_hi = a;
                end else begin
                    res_lo = a / b;
                    res_hi = a % b;
                end
            end
            default: begin
                prod = '0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
// Ports: clk, reset (sync, active-high), start/mdop/in1/in2 op request, req flush,
//        busy (registered), stall (combinational), hi/lo registers.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = MDU_MUL_LAT,
    parameter int DIV_LAT = MDU_DIV_LAT,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdop,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             req,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             accept;

    mdu_unit_calc #(.WIDTH(WIDTH)) u_calc (
        .op     (mdop),
        .a      (in1),
        .b      (in2),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign busy   = (state_q == MDU_RUN);
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign accept = start & ~req & ~busy;
    assign stall  = busy | (start & is_arith_op(mdop) & ~req);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            MDU_IDLE: begin
                if (accept) begin
                    if (is_arith_op(mdop)) begin
                        pend_hi_d = res_hi;
                        pend_lo_d = res_lo;
                        cnt_d     = is_div_op(mdop) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                        state_d   = MDU_RUN;
                    end else if (mdop == MDU_MTHI) begin
                        hi_d = in1;
                    end else if (mdop == MDU_MTLO) begin
                        lo_d = in1;
                    end
                end
            end
            MDU_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Results commit on the same edge busy drops, so they are visible once idle.
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = MDU_IDLE;
                end
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - self-checking bench for mdu_unit with vector table, corner sequences and random ops
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] in1, in2;
    logic        req;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mdu_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .in1   (in1),
        .in2   (in2),
        .req   (req),
        .busy  (busy),
        .stall (stall),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference result {hi,lo} from the architectural definition using 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MDU_MULT:  return 64'(sa * sb);
            MDU_MULTU: return ua * ub;
            MDU_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (sa == -64'sd2147483648 && sb == -64'sd1) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MDU_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic idle_inputs();
        start = 1'b0;
        mdop  = MDU_NONE;
        in1   = '0;
        in2   = '0;
        req   = 1'b0;
    endtask

    // Issue one arithmetic op, measure busy length and compare the committed HI/LO.
    task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int lat;
        int cnt;
        lat = is_div_op(op) ? 10 : 5;
        @(negedge clk);
        start = 1'b1; mdop = op; in1 = a; in2 = b; req = 1'b0;
        #1;
        check({name, " stall"}, {63'd0, stall}, 64'd1);
        @(negedge clk);
        idle_inputs();
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check({name, " latency"}, 64'(cnt), 64'(lat));
        check({name, " hilo"}, {hi, lo}, exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        int          cnt;

        vecs[0] = '{"mult_neg3x5",   MDU_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1};
        vecs[1] = '{"div_neg7_2",    MDU_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
        vecs[2] = '{"divu_7_2",      MDU_DIVU,  32'd7,         32'd2,         64'h0000_0001_0000_0003};
        vecs[3] = '{"divu_by_zero",  MDU_DIVU,  32'h0000_1234, 32'd0,         64'h0000_1234_FFFF_FFFF};
        vecs[4] = '{"div_overflow",  MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[5] = '{"multu_max_x2",  MDU_MULTU, 32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE};
        vecs[6] = '{"mult_min_sq",   MDU_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[7] = '{"div_7_neg2",    MDU_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset busy",  {63'd0, busy},  64'd0);
        check("reset stall", {63'd0, stall}, 64'd0);
        check("reset hilo",  {hi, lo},       64'd0);

        for (int i = 0; i < 8; i++)
            run_md(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Flushed start: nothing accepted, no stall.
        @(negedge clk);
        start = 1'b1; mdop = MDU_MULT; in1 = 32'd2; in2 = 32'd3; req = 1'b1;
        #1;
        check("req stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        idle_inputs();
        check("req busy", {63'd0, busy}, 64'd0);
        check("req hilo", {hi, lo}, vecs[7].exp);

        // MTHI while idle, then an ignored MTHI while busy.
        @(negedge clk);
        start = 1'b1; mdop = MDU_MTHI; in1 = 32'h0000_1111;
        @(negedge clk);
        idle_inputs();
        check("mthi idle", {32'd0, hi}, 64'h1111);
        start = 1'b1; mdop = MDU_MULTU; in1 = 32'd2; in2 = 32'd3;
        @(negedge clk);
        start = 1'b1; mdop = MDU_MTHI; in1 = 32'h0000_AAAA; in2 = '0;
        @(negedge clk);
        idle_inputs();
        check("mthi busy ignored", {32'd0, hi}, 64'h1111);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        check("multu after mthi", {hi, lo}, 64'd6);

        // MTLO while idle.
        start = 1'b1; mdop = MDU_MTLO; in1 = 32'h0000_5555;
        @(negedge clk);
        idle_inputs();
        check("mtlo idle", {hi, lo}, 64'h0000_0000_0000_5555);
        check("mtlo busy", {63'd0, busy}, 64'd0);

        // NONE and the unused encoding leave state untouched.
        start = 1'b1; mdop = MDU_NONE; in1 = 32'hDEAD_BEEF;
        @(negedge clk);
        mdop = 3'd7;
        @(negedge clk);
        idle_inputs();
        check("noop hilo", {hi, lo}, 64'h0000_0000_0000_5555);
        check("noop busy", {63'd0, busy}, 64'd0);

        // Reset in the third busy cycle of a DIV discards it.
        start = 1'b1; mdop = MDU_DIV; in1 = 32'd100; in2 = 32'd7;
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", {63'd0, busy}, 64'd0);
        check("midreset hilo", {hi, lo}, 64'd0);
        repeat (12) @(negedge clk);
        check("midreset no late commit", {hi, lo}, 64'd0);
        run_md("multu_after_reset", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);

        // Random ops against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            rop = 3'(1 + $urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: ra = 32'd0;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            run_md($sformatf("rand%0d op%0d %h %h", i, rop, ra, rb), rop, ra, rb, model(rop, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multiply/divide unit for the P7 pipeline. It sits in E stage beside the ALU and owns the HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU as multi-cycle operations with a busy/stall handshake, and MTHI/MTLO as single-cycle writes.
- Operand width and per-class latency are parameters, so the same unit serves 32-bit and narrower test configurations.
- Interacts with exceptions through a `req` flush input. This supersedes the ad-hoc single-cycle HI/LO logic.

Parameters:
- WIDTH, 32: operand, HI and LO width.
- MUL_LAT, 5: cycles busy for MULT/MULTU (≥1).
- DIV_LAT, 10: cycles busy for DIV/DIVU (≥1).
- CNT_W, 4: latency counter width; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is an MDU op; sampled at posedge.
- mdop  input  3  op select (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_NONE).
- in1  input  WIDTH  rs operand.
- in2  input  WIDTH  rt operand.
- req  input  1  exception/interrupt flush from M stage; suppresses start this cycle.
- busy  output  1  multi-cycle op in flight.
- stall  output  1  combinational: busy | (start & mdop is MULT/MULTU/DIV/DIVU & ~req). Drives the hazard unit's stall for mf*/MDU instructions.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: busy=0, counter=0, hi=0, lo=0, pending result=0. Reset overrides everything, including mid-operation; the in-flight result is discarded.
- An op is accepted at posedge when start=1 & req=0 & busy=0. start while busy is ignored; the pipeline guarantees this via stall.
- Mul/div accept (edge t):
  - Result is computed from in1/in2 and captured into pending_hi/pending_lo.
  - counter loads LAT; busy=1 from t+1.
  - counter decrements each cycle.
  - At the edge where counter goes 1→0: hi/lo load pending values and busy falls. New hi/lo are visible in the first cycle busy=0, so busy is high for exactly LAT cycles.
- MULT: signed 2·WIDTH product, {hi,lo}=product.
- MULTU: unsigned product, {hi,lo}=product.
- DIV: signed, quotient truncates toward zero. lo=quotient, hi=remainder, remainder takes the sign of the dividend.
- DIVU: unsigned, lo=quotient, hi=remainder.
- Divide by zero (DIV/DIVU, in2=0): lo=all-ones, hi=in1. Still takes full DIV_LAT.
- Signed overflow (DIV, in1=MIN_INT, in2=−1): lo=MIN_INT, hi=0.
- MTHI/MTLO accept (busy=0, req=0): hi (resp. lo) ← in1 at that edge; busy unaffected. If busy, the write is ignored.
- req=1 with start=1: nothing accepted, state unchanged. req does not abort an op already in flight.
- mdop=MDU_NONE or an unused encoding with start=1: no effect.
- Outputs hi, lo and busy are registered; stall is the only combinational output.

Decomposition:
- Shared package/header (const.v style `define`s):
  - MDU_* op encodings.
  - Default latencies.
- Sub-module mdu_calc: purely combinational, parameter WIDTH, computes {res_hi, res_lo} for the four arithmetic ops, including the div-by-zero and overflow rules. mdu_unit keeps the counter, handshake and HI/LO registers.

Test Plan:
- MULT in1=FFFFFFFD (−3), in2=5 → busy high exactly 5 cycles, then hi=FFFFFFFF, lo=FFFFFFF1. stall=1 in the start cycle.
- DIV in1=FFFFFFF9 (−7), in2=2 → after 10 cycles lo=FFFFFFFD, hi=FFFFFFFF. DIVU 7/2 → lo=3, hi=1.
- DIVU in1=1234, in2=0 → lo=FFFFFFFF, hi=1234. DIV 80000000/FFFFFFFF → lo=80000000, hi=0.
- start=1 with req=1 (MULT 2×3) → busy stays 0, stall=0, hi/lo unchanged.
- MTHI in1=AAAA while busy → hi unchanged. MTLO in1=5555 with busy=0 → lo=5555 next cycle.
- reset asserted at cycle 3 of a DIV → next cycle busy=0, hi=0, lo=0; a new MULTU FFFFFFFF×2 then gives hi=1, lo=FFFFFFFE.
